// File: rtl/uart_imem_loader.sv
// UART boot loader: receives 9-byte 8N1 frames and turns each valid write frame
// into one 32-bit SIB write on the instruction-memory debug port; also gates cpu_hold.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int FRAME_TIMEOUT = 65536,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic [15:0] sib_addr,
  output logic        sib_sel,
  output logic        sib_enable,
  output logic        sib_write,
  output logic [31:0] sib_wdata,
  output logic [3:0]  sib_mask,
  input  logic [31:0] sib_rdata,
  input  logic        sib_ready,
  input  logic        sib_resp,
  output logic        cpu_hold,
  output logic [7:0]  err_cnt,
  output logic [15:0] wr_cnt,
  output logic [1:0]  rx_state_dbg,
  output logic [3:0]  parse_state_dbg,
  output logic [1:0]  sib_state_dbg
);

  // SIB handshake: a transfer is SETUP for one cycle (sel=1, enable=0), then ACCESS
  // (sel=1, enable=1) held until the target raises sib_ready; sib_resp is valid with ready.

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(FRAME_TIMEOUT);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_M1   = TO_W'(FRAME_TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {P_SYNC, P_CMD, P_A0, P_A1, P_D0, P_D1, P_D2, P_D3, P_CHK} p_state_t;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} s_state_t;

  rx_state_t rx_state;
  p_state_t  p_state;
  s_state_t  s_state;

  logic             rxd_s1, rxd_s2, rxd_prev;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift, rx_byte;
  logic             byte_valid, frame_err;

  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       cmd, chk_acc;
  logic [15:0]      addr;
  logic [31:0]      data;

  logic chk_byte, frame_good, wr_go, frame_reject, timeout_hit, parse_err;
  logic sib_done_ok, sib_err;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic unused_rdata;

  assign unused_rdata    = ^sib_rdata;
  assign rx_state_dbg    = rx_state;
  assign parse_state_dbg = p_state;
  assign sib_state_dbg   = s_state;

  // Receiver: start bit confirmed at half a bit, then every sample lands mid-bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_s1 <= 1'b1; rxd_s2 <= 1'b1; rxd_prev <= 1'b1;
      rx_state <= RX_IDLE; clk_cnt <= '0; bit_idx <= '0;
      shift <= '0; rx_byte <= '0; byte_valid <= 1'b0; frame_err <= 1'b0;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_prev <= rxd_s2;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rxd_prev && !rxd_s2) begin
          clk_cnt <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (clk_cnt == HALF_M1) begin
          clk_cnt <= '0;
          bit_idx <= '0;
          rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
        end else clk_cnt <= clk_cnt + CNT_W'(1);
        RX_DATA: if (clk_cnt == BIT_M1) begin
          clk_cnt <= '0;
          shift <= {rxd_s2, shift[7:1]};
          if (bit_idx == 3'd7) rx_state <= RX_STOP;
          else bit_idx <= bit_idx + 3'd1;
        end else clk_cnt <= clk_cnt + CNT_W'(1);
        RX_STOP: if (clk_cnt == BIT_M1) begin
          clk_cnt <= '0;
          rx_state <= RX_IDLE;
          if (rxd_s2) begin
            rx_byte <= shift;
            byte_valid <= 1'b1;
          end else frame_err <= 1'b1;
        end else clk_cnt <= clk_cnt + CNT_W'(1);
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    chk_byte     = byte_valid && (p_state == P_CHK);
    frame_good   = chk_byte && (chk_acc == rx_byte) &&
                   (cmd == 8'h01 || cmd == 8'h02 || cmd == 8'h03) &&
                   !(cmd == 8'h01 && addr[1:0] != 2'b00);
    wr_go        = frame_good && (cmd == 8'h01) && (s_state == S_IDLE);
    frame_reject = chk_byte && (!frame_good || (cmd == 8'h01 && s_state != S_IDLE));
    timeout_hit  = (p_state != P_SYNC) && !byte_valid && !frame_err && (to_cnt == TO_M1);
    parse_err    = frame_err || timeout_hit || frame_reject;
    sib_done_ok  = (s_state == S_ACCESS) && sib_ready && !sib_resp;
    sib_err      = (s_state == S_ACCESS) && sib_ready && sib_resp;
    err_inc      = {1'b0, parse_err} + {1'b0, sib_err};
    err_sum      = {1'b0, err_cnt} + {7'd0, err_inc};
  end

  // Frame parser; the checksum accumulates CMD through D3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state <= P_SYNC; to_cnt <= '0; cmd <= '0; chk_acc <= '0;
      addr <= '0; data <= '0; cpu_hold <= HOLD_AT_RESET;
    end else if (frame_err) begin
      p_state <= P_SYNC;
      to_cnt <= '0;
    end else if (byte_valid) begin
      to_cnt <= '0;
      case (p_state)
        P_SYNC: if (rx_byte == 8'hA5) p_state <= P_CMD;
        P_CMD: begin cmd <= rx_byte; chk_acc <= rx_byte; p_state <= P_A0; end
        P_A0: begin addr[7:0] <= rx_byte; chk_acc <= chk_acc ^ rx_byte; p_state <= P_A1; end
        P_A1: begin addr[15:8] <= rx_byte; chk_acc <= chk_acc ^ rx_byte; p_state <= P_D0; end
        P_D0, P_D1, P_D2, P_D3: begin
          data <= {rx_byte, data[31:8]};
          chk_acc <= chk_acc ^ rx_byte;
          p_state <= p_state_t'(p_state + 4'd1);
        end
        P_CHK: begin
          p_state <= P_SYNC;
          if (frame_good && cmd == 8'h02) cpu_hold <= 1'b0;
          if (frame_good && cmd == 8'h03) cpu_hold <= 1'b1;
        end
        default: p_state <= P_SYNC;
      endcase
    end else if (p_state != P_SYNC) begin
      if (timeout_hit) begin
        p_state <= P_SYNC;
        to_cnt <= '0;
      end else to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_state <= S_IDLE; sib_addr <= '0; sib_wdata <= '0; sib_sel <= 1'b0;
      sib_enable <= 1'b0; sib_write <= 1'b0; sib_mask <= '0;
    end else begin
      case (s_state)
        S_IDLE: if (wr_go) begin
          sib_addr <= addr; sib_wdata <= data; sib_sel <= 1'b1;
          sib_write <= 1'b1; sib_mask <= 4'hF; s_state <= S_SETUP;
        end
        S_SETUP: begin sib_enable <= 1'b1; s_state <= S_ACCESS; end
        S_ACCESS: if (sib_ready) begin
          sib_addr <= '0; sib_wdata <= '0; sib_sel <= 1'b0;
          sib_enable <= 1'b0; sib_write <= 1'b0; sib_mask <= '0;
          s_state <= S_IDLE;
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  // A frame rejection and a failed SIB completion in the same cycle count as two errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (sib_done_ok) wr_cnt <= wr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: serial frame driver, SIB responder and a write scoreboard.
module tb_uart_imem_loader;
  localparam int CPB = 8;
  localparam int TO  = 256;

  logic        clk = 1'b0, rst_n = 1'b0, uart_rxd = 1'b1;
  logic [15:0] sib_addr, wr_cnt;
  logic        sib_sel, sib_enable, sib_write, sib_ready, sib_resp, cpu_hold;
  logic [31:0] sib_wdata;
  logic [3:0]  sib_mask, parse_state_dbg;
  logic [7:0]  err_cnt;
  logic [1:0]  rx_state_dbg, sib_state_dbg;

  int n_checks = 0, n_pass = 0;
  logic [47:0] exp_q[$];
  int ready_delay = 2;
  logic resp_err = 1'b0;
  int acc_cnt = 0, setup_len = 0, access_len = 0, sel_pulses = 0, done_cnt = 0;
  logic sel_prev = 1'b0;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .FRAME_TIMEOUT(TO), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .reset(rst_n), .uart_rxd(uart_rxd),
    .sib_addr(sib_addr), .sib_sel(sib_sel), .sib_enable(sib_enable), .sib_write(sib_write),
    .sib_wdata(sib_wdata), .sib_mask(sib_mask), .sib_rdata(32'hDEAD_BEEF),
    .sib_ready(sib_ready), .sib_resp(sib_resp), .cpu_hold(cpu_hold),
    .err_cnt(err_cnt), .wr_cnt(wr_cnt), .rx_state_dbg(rx_state_dbg),
    .parse_state_dbg(parse_state_dbg), .sib_state_dbg(sib_state_dbg));

  always #5 clk = ~clk;

  // SIB target: raises ready in access cycle number ready_delay (counting from 0).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (sib_sel && sib_enable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign sib_ready = sib_sel && sib_enable && (acc_cnt == ready_delay);
  assign sib_resp  = sib_ready && resp_err;

  // Scoreboard: every completed transfer must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      setup_len = 0; access_len = 0; sel_pulses = 0; done_cnt = 0; sel_prev = 1'b0;
    end else begin
      if (sib_sel && !sel_prev) sel_pulses++;
      sel_prev = sib_sel;
      if (sib_sel && !sib_enable) setup_len++;
      if (sib_sel && sib_enable) begin
        access_len++;
        if (sib_ready) begin
          done_cnt++;
          n_checks++;
          if (exp_q.size() == 0)
            $display("FAIL sb_unexpected got addr=%h data=%h exp none", sib_addr, sib_wdata);
          else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            if ({sib_addr, sib_wdata} !== e)
              $display("FAIL sb_write got addr=%h data=%h exp addr=%h data=%h",
                       sib_addr, sib_wdata, e[47:32], e[31:0]);
            else n_pass++;
          end
          n_checks++;
          if (sib_mask !== 4'hF || sib_write !== 1'b1)
            $display("FAIL sb_ctrl got mask=%h write=%b exp mask=f write=1", sib_mask, sib_write);
          else n_pass++;
          n_checks++;
          if (setup_len != 1 || access_len != ready_delay + 1)
            $display("FAIL sb_phases got setup=%0d access=%0d exp setup=1 access=%0d",
                     setup_len, access_len, ready_delay + 1);
          else n_pass++;
          setup_len = 0;
          access_len = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; uart_rxd = 1'b1; ready_delay = 2; resp_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // bad_idx: byte sent with a 0 stop bit; glitch_idx: byte followed by a 1-cycle low pulse.
  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] data,
                            input logic [7:0] chk_flip, input int bad_idx, input int glitch_idx);
    logic [7:0] b [9];
    b[0] = 8'hA5; b[1] = cmd; b[2] = addr[7:0]; b[3] = addr[15:8];
    b[4] = data[7:0]; b[5] = data[15:8]; b[6] = data[23:16]; b[7] = data[31:24];
    b[8] = chk_flip;
    for (int i = 1; i < 8; i++) b[8] = b[8] ^ b[i];
    for (int i = 0; i < 9; i++) begin
      send_byte(b[i], i != bad_idx);
      if (i == glitch_idx) begin
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    repeat (4) @(negedge clk);
    while (sib_sel && n < bound) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= bound) $display("FAIL wait_idle got sel=1 after %0d cycles exp sel=0", n);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({sib_sel, sib_enable, sib_write, sib_mask} !== 7'd0)
      $display("FAIL reset_ctrl got sel=%b en=%b wr=%b mask=%h exp 0", sib_sel, sib_enable, sib_write, sib_mask);
    else n_pass++;
    n_checks++;
    if ({sib_addr, sib_wdata} !== 48'd0)
      $display("FAIL reset_bus got addr=%h data=%h exp 0", sib_addr, sib_wdata);
    else n_pass++;
    n_checks++;
    if (cpu_hold !== 1'b1 || err_cnt !== 8'd0 || wr_cnt !== 16'd0)
      $display("FAIL reset_status got hold=%b err=%0d wr=%0d exp hold=1 err=0 wr=0", cpu_hold, err_cnt, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_good_write();
    do_reset();
    exp_q.push_back({16'h0010, 32'h1234_5678});
    send_frame(8'h01, 16'h0010, 32'h1234_5678, 8'h00, -1, -1);
    wait_idle(50);
    n_checks++;
    if (wr_cnt !== 16'd1 || err_cnt !== 8'd0 || sel_pulses != 1)
      $display("FAIL good_write got wr=%0d err=%0d sel=%0d exp wr=1 err=0 sel=1", wr_cnt, err_cnt, sel_pulses);
    else n_pass++;
  endtask

  task automatic test_bad_chk();
    do_reset();
    send_frame(8'h01, 16'h0010, 32'h1234_5678, 8'h01, -1, -1);
    wait_idle(50);
    n_checks++;
    if (sel_pulses != 0 || err_cnt !== 8'd1)
      $display("FAIL bad_chk got sel=%0d err=%0d exp sel=0 err=1", sel_pulses, err_cnt);
    else n_pass++;
    exp_q.push_back({16'h0010, 32'h1234_5678});
    send_frame(8'h01, 16'h0010, 32'h1234_5678, 8'h00, -1, -1);
    wait_idle(50);
    n_checks++;
    if (wr_cnt !== 16'd1 || err_cnt !== 8'd1)
      $display("FAIL bad_chk_recover got wr=%0d err=%0d exp wr=1 err=1", wr_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_reject_cmds();
    do_reset();
    send_frame(8'h01, 16'h0012, 32'h1234_5678, 8'h00, -1, -1);
    wait_idle(50);
    n_checks++;
    if (sel_pulses != 0 || err_cnt !== 8'd1 || wr_cnt !== 16'd0)
      $display("FAIL misaligned got sel=%0d err=%0d wr=%0d exp sel=0 err=1 wr=0", sel_pulses, err_cnt, wr_cnt);
    else n_pass++;
    send_frame(8'h05, 16'h0010, 32'h1234_5678, 8'h00, -1, -1);
    wait_idle(50);
    n_checks++;
    if (sel_pulses != 0 || err_cnt !== 8'd2 || cpu_hold !== 1'b1)
      $display("FAIL bad_cmd got sel=%0d err=%0d hold=%b exp sel=0 err=2 hold=1", sel_pulses, err_cnt, cpu_hold);
    else n_pass++;
  endtask

  task automatic test_cpu_hold();
    do_reset();
    send_frame(8'h02, 16'h0000, 32'h0, 8'h00, -1, -1);
    wait_idle(50);
    n_checks++;
    if (cpu_hold !== 1'b0 || err_cnt !== 8'd0)
      $display("FAIL hold_release got hold=%b err=%0d exp hold=0 err=0", cpu_hold, err_cnt);
    else n_pass++;
    send_frame(8'h03, 16'h0000, 32'h0, 8'h00, -1, -1);
    wait_idle(50);
    n_checks++;
    if (cpu_hold !== 1'b1 || sel_pulses != 0)
      $display("FAIL hold_set got hold=%b sel=%0d exp hold=1 sel=0", cpu_hold, sel_pulses);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (300) @(negedge clk);
    n_checks++;
    if (err_cnt !== 8'd1) $display("FAIL timeout got err=%0d exp 1", err_cnt);
    else n_pass++;
    exp_q.push_back({16'h0020, 32'hCAFE_F00D});
    send_frame(8'h01, 16'h0020, 32'hCAFE_F00D, 8'h00, -1, -1);
    wait_idle(50);
    n_checks++;
    if (wr_cnt !== 16'd1 || err_cnt !== 8'd1)
      $display("FAIL timeout_recover got wr=%0d err=%0d exp wr=1 err=1", wr_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_framing_glitch();
    do_reset();
    send_frame(8'h01, 16'h0010, 32'h1234_5678, 8'h00, 3, -1);
    wait_idle(50);
    n_checks++;
    if (err_cnt !== 8'd1 || wr_cnt !== 16'd0 || sel_pulses != 0)
      $display("FAIL framing got err=%0d wr=%0d sel=%0d exp err=1 wr=0 sel=0", err_cnt, wr_cnt, sel_pulses);
    else n_pass++;
    do_reset();
    exp_q.push_back({16'h0044, 32'h0BAD_C0DE});
    send_frame(8'h01, 16'h0044, 32'h0BAD_C0DE, 8'h00, -1, 0);
    wait_idle(50);
    n_checks++;
    if (err_cnt !== 8'd0 || wr_cnt !== 16'd1)
      $display("FAIL glitch got err=%0d wr=%0d exp err=0 wr=1", err_cnt, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_sib_error();
    do_reset();
    resp_err = 1'b1;
    exp_q.push_back({16'h0100, 32'h5555_AAAA});
    send_frame(8'h01, 16'h0100, 32'h5555_AAAA, 8'h00, -1, -1);
    wait_idle(50);
    n_checks++;
    if (err_cnt !== 8'd1 || wr_cnt !== 16'd0 || done_cnt != 1)
      $display("FAIL sib_error got err=%0d wr=%0d done=%0d exp err=1 wr=0 done=1", err_cnt, wr_cnt, done_cnt);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    ready_delay = 2000;
    exp_q.push_back({16'h0200, 32'h1111_2222});
    send_frame(8'h01, 16'h0200, 32'h1111_2222, 8'h00, -1, -1);
    send_frame(8'h02, 16'h0000, 32'h0, 8'h00, -1, -1);
    send_frame(8'h01, 16'h0204, 32'h3333_4444, 8'h00, -1, -1);
    n_checks++;
    if (cpu_hold !== 1'b0 || err_cnt !== 8'd1 || sib_sel !== 1'b1)
      $display("FAIL overrun got hold=%b err=%0d sel=%b exp hold=0 err=1 sel=1", cpu_hold, err_cnt, sib_sel);
    else n_pass++;
    wait_idle(3000);
    n_checks++;
    if (wr_cnt !== 16'd1 || done_cnt != 1 || exp_q.size() != 0)
      $display("FAIL overrun_done got wr=%0d done=%0d pending=%0d exp wr=1 done=1 pending=0",
               wr_cnt, done_cnt, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC;
      d = $urandom;
      exp_q.push_back({a, d});
      send_frame(8'h01, a, d, 8'h00, -1, -1);
    end
    wait_idle(50);
    n_checks++;
    if (wr_cnt !== 16'd4 || err_cnt !== 8'd0 || exp_q.size() != 0)
      $display("FAIL back_to_back got wr=%0d err=%0d pending=%0d exp wr=4 err=0 pending=0",
               wr_cnt, err_cnt, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    ready_delay = 50;
    send_frame(8'h01, 16'h0300, 32'h7777_8888, 8'h00, -1, -1);
    while (!sib_enable && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (n >= 100 || sib_sel !== 1'b0 || sib_enable !== 1'b0 || sib_addr !== 16'd0)
      $display("FAIL reset_mid got sel=%b en=%b addr=%h wait=%0d exp sel=0 en=0 addr=0",
               sib_sel, sib_enable, sib_addr, n);
    else n_pass++;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_good_write();
    test_bad_chk();
    test_reject_cmds();
    test_cpu_hold();
    test_timeout();
    test_framing_glitch();
    test_sib_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
